// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: reads a 32-bit little-endian instruction as four
// byte reads, presents it to decode, then advances or redirects the PC.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | requesting bytes pc+0..pc+3, one per mem_ack
// HOLD   | instruction complete, instr_valid high until decode accepts it
// UPDATE | one-cycle PC load strobe (pc+4, or the redirect target)
module ifetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_current_address,
    output logic               load,
    output logic [ADDR_W-1:0]  pc_target_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [7:0]         mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(4);

    state_t              state, state_nxt;
    logic [1:0]          byte_cnt, byte_cnt_nxt;
    logic [INSTR_W-1:0]  instr_nxt;
    logic [ADDR_W-1:0]   target_nxt;
    logic [ADDR_W-1:0]   byte_ofs;

    assign byte_ofs = ADDR_W'(byte_cnt);

    // State, byte counter, assembled instruction and load target registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= FETCH;
            byte_cnt       <= 2'd0;
            instr          <= '0;
            pc_target_addr <= '0;
        end else begin
            state          <= state_nxt;
            byte_cnt       <= byte_cnt_nxt;
            instr          <= instr_nxt;
            pc_target_addr <= target_nxt;
        end
    end

    // Next-state logic and handshake outputs; redirect overrides every state
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        instr_nxt    = instr;
        target_nxt   = pc_target_addr;

        // Outputs are qualified with rst so they read zero while reset is held,
        // even though the reset state is FETCH.
        mem_req     = rst && (state == FETCH);
        mem_addr    = mem_req ? (pc_current_address + byte_ofs) : '0;
        instr_valid = rst && (state == HOLD) && !redirect;
        load        = rst && (state == UPDATE);

        if (redirect) begin
            // Abort any partial fetch; a redirect during UPDATE simply replaces
            // the pending target and keeps the block in UPDATE.
            state_nxt    = UPDATE;
            byte_cnt_nxt = 2'd0;
            target_nxt   = redirect_addr;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        instr_nxt[{byte_cnt, 3'b000} +: 8] = mem_rdata;
                        byte_cnt_nxt = byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_nxt  = UPDATE;
                        target_nxt = pc_current_address + INSTR_BYTES;
                    end
                end
                UPDATE: begin
                    state_nxt = FETCH;
                end
                default: begin
                    state_nxt    = FETCH;
                    byte_cnt_nxt = 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: byte memory with configurable wait states, a PC
// register model, a table of fetch vectors and scoreboard queues for byte
// addresses, delivered instructions and PC load targets.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  pc_reg;
    logic        load;
    logic [7:0]  pc_target_addr;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_addr;

    ifetch_unit #(.ADDR_W(8), .INSTR_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .pc_current_address (pc_reg),
        .load               (load),
        .pc_target_addr     (pc_target_addr),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .instr              (instr),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .redirect           (redirect),
        .redirect_addr      (redirect_addr)
    );

    always #5 clk = ~clk;

    // Byte memory: acks after wait_cfg stall cycles; stray forces an ack
    // with junk data regardless of mem_req.
    logic [7:0] mem [256];
    int         wait_cfg = 0;
    int         wait_cnt = 0;
    logic       stray = 1'b0;

    assign mem_ack   = (mem_req && (wait_cnt == wait_cfg)) || stray;
    assign mem_rdata = stray ? 8'hA5 : mem[mem_addr];

    always @(posedge clk) begin
        wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    end

    // PC register being driven by the fetch unit
    always @(posedge clk or negedge rst) begin
        if (!rst) pc_reg <= 8'h00;
        else if (load) pc_reg <= pc_target_addr;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  exp_addr_q [$];
    logic [31:0] exp_instr_q [$];
    logic [7:0]  exp_tgt_q [$];
    logic [7:0]  cur_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %h with nothing expected at %0t", name, act, $time);
    endtask

    function automatic logic [31:0] assemble(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a]};
    endfunction

    // Scoreboard monitor, sampled mid-cycle
    logic [7:0] prev_addr = 8'h00;
    logic       prev_pend = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (mem_req && mem_ack) begin
                if (exp_addr_q.size() == 0) miss("mem_addr", 32'(mem_addr));
                else chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (prev_pend && mem_req) chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
            prev_pend = mem_req && !mem_ack;
            prev_addr = mem_addr;
            if (instr_valid && instr_ready) begin
                if (exp_instr_q.size() == 0) miss("instr", instr);
                else chk("instr", instr, exp_instr_q.pop_front());
            end
            if (load) begin
                if (exp_tgt_q.size() == 0) miss("pc_target_addr", 32'(pc_target_addr));
                else chk("pc_target_addr", 32'(pc_target_addr), 32'(exp_tgt_q.pop_front()));
            end
        end else begin
            prev_pend = 1'b0;
        end
    end

    typedef struct {
        int         waitc;
        int         hold;
        bit         redir;
        logic [7:0] raddr;
    } vec_t;

    vec_t vecs [7];

    // One complete fetch from cur_pc; called from the middle of the cycle
    // before FETCH begins, returns in the middle of the UPDATE cycle.
    task automatic run_vec(input vec_t v);
        int          n;
        int          lat;
        logic [31:0] held;
        logic [7:0]  tgt;
        tgt = v.redir ? v.raddr : cur_pc + 8'd4;
        wait_cfg    = v.waitc;
        instr_ready = (v.hold == 0) && !v.redir;
        redirect    = 1'b0;
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(cur_pc + 8'(i));
        if (!v.redir) exp_instr_q.push_back(assemble(cur_pc));
        exp_tgt_q.push_back(tgt);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        chk("fetch_start", 32'(mem_req), 32'd1);
        lat = 0;
        while (!instr_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("fetch_latency", lat, 4 * (v.waitc + 1));
        chk("req_drop", 32'(mem_req), 32'd0);
        if (v.hold > 0 || v.redir) begin
            held  = instr;
            stray = 1'b1;
            for (int k = 1; k < v.hold; k++) begin
                @(negedge clk);
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_instr", instr, held);
                chk("hold_no_load", 32'(load), 32'd0);
            end
            @(posedge clk);
            #1;
            stray         = 1'b0;
            instr_ready   = 1'b1;
            redirect      = v.redir;
            redirect_addr = v.raddr;
            @(negedge clk);
            chk("valid_at_accept", 32'(instr_valid), 32'(!v.redir));
            @(posedge clk);
            #1;
            instr_ready = 1'b0;
            redirect    = 1'b0;
        end
        @(negedge clk);
        chk("update_load", 32'(load), 32'd1);
        chk("update_valid", 32'(instr_valid), 32'd0);
        cur_pc = tgt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{waitc: 0, hold: 0, redir: 1'b0, raddr: 8'h00};
        vecs[1] = '{waitc: 2, hold: 0, redir: 1'b0, raddr: 8'h00};
        vecs[2] = '{waitc: 0, hold: 5, redir: 1'b0, raddr: 8'h00};
        vecs[3] = '{waitc: 1, hold: 2, redir: 1'b1, raddr: 8'hFC};
        vecs[4] = '{waitc: 0, hold: 0, redir: 1'b0, raddr: 8'h00};
        vecs[5] = '{waitc: 0, hold: 1, redir: 1'b1, raddr: 8'hFE};
        vecs[6] = '{waitc: 1, hold: 0, redir: 1'b0, raddr: 8'h00};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h13;
        mem[1] = 8'h00;
        mem[2] = 8'h00;
        mem[3] = 8'h00;

        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 8'h00;
        cur_pc        = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_target", 32'(pc_target_addr), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Redirect after byte 1, then a second redirect landing in UPDATE
        wait_cfg    = 0;
        instr_ready = 1'b0;
        exp_addr_q.push_back(cur_pc);
        exp_addr_q.push_back(cur_pc + 8'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        @(negedge clk);
        @(posedge clk);
        #1;
        wait_cfg      = 5;
        redirect      = 1'b1;
        redirect_addr = 8'h30;
        exp_tgt_q.push_back(8'h30);
        exp_tgt_q.push_back(8'h40);
        @(negedge clk);
        chk("redir_cycle_addr", 32'(mem_addr), 32'(cur_pc + 8'd2));
        @(posedge clk);
        #1;
        redirect_addr = 8'h40;
        @(negedge clk);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_load", 32'(load), 32'd1);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("reload_load", 32'(load), 32'd1);
        cur_pc = 8'h40;
        run_vec('{waitc: 0, hold: 0, redir: 1'b0, raddr: 8'h00});

        // Asynchronous reset in the middle of a stalled fetch
        wait_cfg = 3;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_load", 32'(load), 32'd0);
        chk("arst_target", 32'(pc_target_addr), 32'd0);
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_valid", 32'(instr_valid), 32'd0);

        chk("addr_q_left", exp_addr_q.size(), 32'd0);
        chk("instr_q_left", exp_instr_q.size(), 32'd0);
        chk("tgt_q_left", exp_tgt_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch sequencer that consumes the PC register's current address and produces that register's load/target inputs. It reads one 32-bit little-endian instruction as four byte reads from the byte-wide instruction memory, using a req/ack handshake. It presents the assembled instruction to decode on a valid/ready handshake, then advances the PC by 4, or redirects it to a branch/jump target supplied by execute.

Parameters:
ADDR_W, 8, PC/memory byte-address width; all address arithmetic is modulo 2^ADDR_W.
INSTR_W, 32, instruction width; fixed at 4 bytes, and other values are unsupported.

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst  input  1  reset; asynchronous, active-low (asserted at 0).
pc_current_address  input  ADDR_W  current PC from the PC register.
load  output  1  one-cycle PC load strobe to the PC register.
pc_target_addr  output  ADDR_W  value the PC register takes when load=1.
mem_req  output  1  byte read request to instruction memory.
mem_addr  output  ADDR_W  byte address of the current request.
mem_ack  input  1  memory has placed the requested byte on mem_rdata this cycle.
mem_rdata  input  8  returned byte.
instr  output  INSTR_W  assembled instruction.
instr_valid  output  1  instr holds a complete instruction for decode.
instr_ready  input  1  decode accepts instr this cycle.
redirect  input  1  execute requests a PC redirect (taken branch/jump).
redirect_addr  input  ADDR_W  redirect target.

Behaviour:
- Reset (rst=0, async) values: state=FETCH, byte_cnt=0, load=0, pc_target_addr=0, mem_req=0, mem_addr=0, instr=0, instr_valid=0. The PC register also resets to 0, so the first fetch is from address 0.
- State FETCH:
  - mem_req=1 and mem_addr=pc_current_address+byte_cnt (wraps mod 2^ADDR_W).
  - mem_addr is held stable until mem_ack.
  - On mem_ack, mem_rdata is written to instr[8*byte_cnt+7:8*byte_cnt] (little-endian) and byte_cnt increments.
  - mem_req stays 1 between bytes. The next address appears in the cycle after the ack.
  - On the ack of byte 3: byte_cnt returns to 0, mem_req drops next cycle, and the block goes to HOLD.
  - Minimum fetch latency is 4 cycles with zero-wait memory (ack in the same cycle as req).
- State HOLD:
  - instr_valid=1 and instr stable.
  - On instr_valid & instr_ready, go to UPDATE.
  - Valid is held indefinitely while ready=0.
- State UPDATE (one cycle):
  - load=1 and pc_target_addr=pc_current_address+4 (mod 2^ADDR_W).
  - Next state is FETCH. The PC register updates on this edge, so the next FETCH cycle addresses the new PC.
- Redirect (priority over everything except reset; sampled in any state):
  - The next cycle is UPDATE with pc_target_addr=redirect_addr.
  - Any partial fetch is aborted: mem_req drops and byte_cnt is cleared.
  - instr_valid is forced to 0 combinationally in any cycle with redirect=1. No decode handshake completes in that cycle, even if instr_ready=1.
  - Redirect arriving during UPDATE: the load target is replaced by the new redirect_addr, the block stays in UPDATE one more cycle, and the last redirect wins.
- load is high only in UPDATE; it is never asserted in two consecutive cycles except under back-to-back redirects.
- A mem_ack arriving while mem_req=0 is ignored.
- Reset mid-fetch or mid-hold: immediate return to the reset values. Memory must tolerate a dropped req.
- No pipelining: at most one instruction is in flight, and fetch of the next instruction starts only after UPDATE.

Test Plan:
- Reset then zero-wait memory with bytes 0x13,0x00,0x00,0x00 at 0..3 and ready=1 -> mem_addr sequence 0,1,2,3; instr=0x00000013 with instr_valid for 1 cycle; load=1 with pc_target_addr=4; next mem_addr=4.
- Memory acks each byte after 2 wait cycles -> mem_addr held stable while unacked; instr_valid rises 12 cycles after fetch start; assembled bytes are correct.
- instr_ready=0 for 5 cycles in HOLD -> instr_valid and instr stable for 5 cycles; no load; UPDATE follows the first ready=1.
- redirect=1 with redirect_addr=0x40 after byte 1 is acked -> mem_req drops; load=1 with pc_target_addr=0x40 next cycle; following fetch reads 0x40..0x43.
- PC=0xFC, then PC=0xFE via redirect -> PC=0xFC gives pc_target_addr=0x00 after fetch. The PC=0xFE fetch gives byte addresses 0xFE,0xFF,0x00,0x01 and a target of 0x02.
- redirect and instr_ready both 1 in HOLD -> instr_valid=0 that cycle; target=redirect_addr; then rst=0 mid-FETCH -> all outputs 0 asynchronously.
